// File: rtl/multi_lane_hit_judge_pkg.sv
// Shared types and constants for the multi-lane hit judge.
//   grade_e      : press grade reported per lane (NONE/OK/GREAT/PERFECT)
//   lane_state_e : per-lane window state (IDLE/OPEN)
//   PTS_*        : points awarded per grade, single BCD digit
//   pts_of()     : grade -> BCD points digit
package gv_judge_pkg;

    typedef enum logic [1:0] {
        NONE    = 2'd0,
        OK      = 2'd1,
        GREAT   = 2'd2,
        PERFECT = 2'd3
    } grade_e;

    typedef enum logic {
        IDLE = 1'b0,
        OPEN = 1'b1
    } lane_state_e;

    localparam logic [3:0] PTS_OK      = 4'd1;
    localparam logic [3:0] PTS_GREAT   = 4'd3;
    localparam logic [3:0] PTS_PERFECT = 4'd5;

    function automatic logic [3:0] pts_of(input grade_e g);
        case (g)
            PERFECT: return PTS_PERFECT;
            GREAT:   return PTS_GREAT;
            OK:      return PTS_OK;
            default: return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/multi_lane_hit_judge_if.sv
// Bus between the note scroller / press debouncers (master) and the judge (slave).
//   score_clr, note_open[LANES], pushed[LANES]         : master -> judge
//   score, num_misses, combo (BCD), judge_vld,
//   judge_grade[2*LANES], hit_flash, miss_flash        : judge -> master
interface multi_lane_hit_judge_if #(
    parameter int LANES  = 4,
    parameter int DIGITS = 4
);
    logic                  score_clr;
    logic [LANES-1:0]      note_open;
    logic [LANES-1:0]      pushed;
    logic [4*DIGITS-1:0]   score;
    logic [4*DIGITS-1:0]   num_misses;
    logic [4*DIGITS-1:0]   combo;
    logic                  judge_vld;
    logic [2*LANES-1:0]    judge_grade;
    logic [LANES-1:0]      hit_flash;
    logic [LANES-1:0]      miss_flash;

    modport master (
        output score_clr, note_open, pushed,
        input  score, num_misses, combo, judge_vld, judge_grade, hit_flash, miss_flash
    );

    modport slave (
        input  score_clr, note_open, pushed,
        output score, num_misses, combo, judge_vld, judge_grade, hit_flash, miss_flash
    );
endinterface

// File: rtl/multi_lane_hit_judge_bcd_add_sat.sv
// bcd_add_sat: combinational DIGITS-digit BCD adder, result saturates at all 9s.
//   a, b : BCD operands (assumed valid BCD)
//   sum  : a + b, or all 9s on overflow out of the top digit
module bcd_add_sat
    import gv_judge_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    output logic [4*DIGITS-1:0] sum
);

    logic [4*DIGITS-1:0] raw;
    logic                carry;
    logic [4:0]          dsum;

    always_comb begin
        raw   = '0;
        carry = 1'b0;
        dsum  = '0;
        for (int d = 0; d < DIGITS; d++) begin
            dsum = {1'b0, a[4*d +: 4]} + {1'b0, b[4*d +: 4]} + {4'b0, carry};
            if (dsum > 5'd9) begin
                // +6 skips the six unused codes; the low nibble is the corrected digit
                raw[4*d +: 4] = 4'(dsum + 5'd6);
                carry         = 1'b1;
            end else begin
                raw[4*d +: 4] = dsum[3:0];
                carry         = 1'b0;
            end
        end
        sum = carry ? {DIGITS{4'h9}} : raw;
    end

endmodule

// File: rtl/multi_lane_hit_judge.sv
// multi_lane_hit_judge: per-lane timed hit windows, press grading, BCD score,
// miss count and combo, per-lane hit/miss flashes.
//   clk, n_rst : clock, asynchronous active-low reset
//   bus        : multi_lane_hit_judge_if.slave (inputs score_clr/note_open/pushed,
//                outputs score/num_misses/combo/judge_vld/judge_grade/flashes)
//
// Lane FSM states:
//   state | meaning
//   IDLE  | no window; a press here is a stray miss
//   OPEN  | window running, cnt_q = cycles since the early edge (0 .. 2*WIN_OK)
//
// Pipeline: lane events are registered into judge_vld/grade/miss (t+1), and the
// registered copy feeds the BCD adders for score/misses/combo (t+2).
module multi_lane_hit_judge
    import gv_judge_pkg::*;
#(
    parameter int LANES       = 4,
    parameter int WIN_OK      = 1100000,
    parameter int WIN_GREAT   = 400000,
    parameter int WIN_PERFECT = 200000,
    parameter int FLASH_CYC   = 1000000,
    parameter int DIGITS      = 4
) (
    input  logic                  clk,
    input  logic                  n_rst,
    multi_lane_hit_judge_if.slave bus
);

    localparam int CW = $clog2(2*WIN_OK + 1);
    localparam int FW = $clog2(FLASH_CYC + 1);
    localparam int NW = 4*DIGITS;

    localparam logic [CW-1:0] K_OK    = CW'(WIN_OK);
    localparam logic [CW-1:0] K_GREAT = CW'(WIN_GREAT);
    localparam logic [CW-1:0] K_PERF  = CW'(WIN_PERFECT);
    localparam logic [CW-1:0] K_END   = CW'(2*WIN_OK);
    localparam logic [FW-1:0] K_FLASH = FW'(FLASH_CYC);

    function automatic grade_e grade_at(input logic [CW-1:0] c);
        logic [CW-1:0] d;
        d = (c >= K_OK) ? (c - K_OK) : (K_OK - c);
        if (d <= K_PERF)       return PERFECT;
        else if (d <= K_GREAT) return GREAT;
        else                   return OK;
    endfunction

    logic [LANES-1:0]   hit_c, miss_c;
    logic [2*LANES-1:0] grade_c;
    logic               vld_q;
    logic [2*LANES-1:0] grade_q;
    logic [LANES-1:0]   miss_q;
    logic [LANES-1:0]   hit_flash_v, miss_flash_v;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        lane_state_e   state_q, state_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic          hit_l, miss_l;
        grade_e        grade_l;
        logic [FW-1:0] hit_fc, miss_fc;

        always_ff @(posedge clk or negedge n_rst) begin
            if (!n_rst) begin
                state_q <= IDLE;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            hit_l   = 1'b0;
            miss_l  = 1'b0;
            grade_l = NONE;
            if (bus.score_clr) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (bus.note_open[i] && bus.pushed[i]) begin
                            // window opens and is consumed at once, graded at cnt=0
                            hit_l   = 1'b1;
                            grade_l = grade_at('0);
                        end else if (bus.note_open[i]) begin
                            state_d = OPEN;
                            cnt_d   = '0;
                        end else if (bus.pushed[i]) begin
                            miss_l = 1'b1;
                        end
                    end
                    OPEN: begin
                        if (bus.pushed[i]) begin
                            // the press belongs to the running window; a coincident
                            // note_open starts the next window fresh
                            hit_l   = 1'b1;
                            grade_l = grade_at(cnt_q);
                            state_d = bus.note_open[i] ? OPEN : IDLE;
                            cnt_d   = '0;
                        end else if (bus.note_open[i]) begin
                            miss_l = 1'b1;
                            cnt_d  = '0;
                        end else if (cnt_q == K_END) begin
                            miss_l  = 1'b1;
                            state_d = IDLE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                    default: begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                endcase
            end
        end

        assign hit_c[i]          = hit_l;
        assign miss_c[i]         = miss_l;
        assign grade_c[2*i +: 2] = grade_l;

        always_ff @(posedge clk or negedge n_rst) begin
            if (!n_rst) begin
                hit_fc  <= '0;
                miss_fc <= '0;
            end else if (bus.score_clr) begin
                hit_fc  <= '0;
                miss_fc <= '0;
            end else begin
                if (hit_l)              hit_fc <= K_FLASH;
                else if (hit_fc != '0)  hit_fc <= hit_fc - FW'(1);
                if (miss_l)             miss_fc <= K_FLASH;
                else if (miss_fc != '0) miss_fc <= miss_fc - FW'(1);
            end
        end

        assign hit_flash_v[i]  = (hit_fc != '0);
        assign miss_flash_v[i] = (miss_fc != '0);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            vld_q   <= 1'b0;
            grade_q <= '0;
            miss_q  <= '0;
        end else if (bus.score_clr) begin
            vld_q   <= 1'b0;
            grade_q <= '0;
            miss_q  <= '0;
        end else begin
            vld_q   <= |(hit_c | miss_c);
            grade_q <= grade_c;
            miss_q  <= miss_c;
        end
    end

    // Per-lane points summed through a chain of BCD adders
    logic [LANES:0][NW-1:0] lane_acc;
    assign lane_acc[0] = '0;

    for (genvar i = 0; i < LANES; i++) begin : g_sum
        logic [NW-1:0] pts_bcd;
        assign pts_bcd = {{(NW-4){1'b0}}, pts_of(grade_e'(grade_q[2*i +: 2]))};
        bcd_add_sat #(.DIGITS(DIGITS)) u_lane_add (
            .a   (lane_acc[i]),
            .b   (pts_bcd),
            .sum (lane_acc[i+1])
        );
    end

    logic [3:0] hit_cnt, miss_cnt;
    always_comb begin
        hit_cnt  = '0;
        miss_cnt = '0;
        for (int i = 0; i < LANES; i++) begin
            hit_cnt  = hit_cnt  + {3'b0, (grade_q[2*i +: 2] != 2'b00)};
            miss_cnt = miss_cnt + {3'b0, miss_q[i]};
        end
    end

    logic [NW-1:0] score_q, misses_q, combo_q;
    logic [NW-1:0] score_sum, misses_sum, combo_sum;

    bcd_add_sat #(.DIGITS(DIGITS)) u_score_add (
        .a   (score_q),
        .b   (lane_acc[LANES]),
        .sum (score_sum)
    );

    bcd_add_sat #(.DIGITS(DIGITS)) u_miss_add (
        .a   (misses_q),
        .b   ({{(NW-4){1'b0}}, miss_cnt}),
        .sum (misses_sum)
    );

    bcd_add_sat #(.DIGITS(DIGITS)) u_combo_add (
        .a   (combo_q),
        .b   ({{(NW-4){1'b0}}, hit_cnt}),
        .sum (combo_sum)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            score_q  <= '0;
            misses_q <= '0;
            combo_q  <= '0;
        end else if (bus.score_clr) begin
            score_q  <= '0;
            misses_q <= '0;
            combo_q  <= '0;
        end else begin
            score_q  <= score_sum;
            misses_q <= misses_sum;
            // any miss in the cycle breaks the combo, even alongside hits
            combo_q  <= (|miss_q) ? '0 : combo_sum;
        end
    end

    assign bus.score       = score_q;
    assign bus.num_misses  = misses_q;
    assign bus.combo       = combo_q;
    assign bus.judge_vld   = vld_q;
    assign bus.judge_grade = grade_q;
    assign bus.hit_flash   = hit_flash_v;
    assign bus.miss_flash  = miss_flash_v;

endmodule

// File: tb/tb_multi_lane_hit_judge.sv
module tb_multi_lane_hit_judge;

    logic clk = 1'b0;
    logic n_rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    multi_lane_hit_judge_if #(.LANES(2), .DIGITS(4)) bus ();

    multi_lane_hit_judge #(
        .LANES(2), .WIN_OK(10), .WIN_GREAT(6), .WIN_PERFECT(2),
        .FLASH_CYC(5), .DIGITS(4)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    // drive inputs for one clock; returns at the following negedge
    task automatic cyc(input logic [1:0] no, input logic [1:0] pu);
        bus.note_open = no;
        bus.pushed    = pu;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(2'b00, 2'b00);
    endtask

    task automatic clr();
        bus.score_clr = 1'b1;
        cyc(2'b00, 2'b00);
        bus.score_clr = 1'b0;
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        bus.score_clr = 1'b0;
        bus.note_open = '0;
        bus.pushed    = '0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (bus.score !== 16'h0000) begin n_bad++; $display("FAIL rst_score got %h want 0000", bus.score); end
        n_cmp++; if (bus.num_misses !== 16'h0000) begin n_bad++; $display("FAIL rst_misses got %h want 0000", bus.num_misses); end
        n_cmp++; if (bus.combo !== 16'h0000) begin n_bad++; $display("FAIL rst_combo got %h want 0000", bus.combo); end
        n_cmp++; if ({bus.judge_vld, bus.judge_grade, bus.hit_flash, bus.miss_flash} !== 9'b0) begin n_bad++; $display("FAIL rst_flags got %b want 0", {bus.judge_vld, bus.judge_grade, bus.hit_flash, bus.miss_flash}); end
        n_rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_perfect();
        clr();
        cyc(2'b01, 2'b00);
        idle(10);
        cyc(2'b00, 2'b01);
        n_cmp++; if (bus.judge_vld !== 1'b1) begin n_bad++; $display("FAIL t1_vld got %b want 1", bus.judge_vld); end
        n_cmp++; if (bus.judge_grade !== 4'b0011) begin n_bad++; $display("FAIL t1_grade got %b want 0011", bus.judge_grade); end
        for (int k = 0; k < 6; k++) begin
            n_cmp++; if (bus.hit_flash[0] !== (k < 5)) begin n_bad++; $display("FAIL t1_flash_%0d got %b want %b", k, bus.hit_flash[0], (k < 5)); end
            if (k == 1) begin
                n_cmp++; if (bus.score !== 16'h0005) begin n_bad++; $display("FAIL t1_score got %h want 0005", bus.score); end
                n_cmp++; if (bus.combo !== 16'h0001) begin n_bad++; $display("FAIL t1_combo got %h want 0001", bus.combo); end
                n_cmp++; if (bus.judge_vld !== 1'b0) begin n_bad++; $display("FAIL t1_vld_pulse got %b want 0", bus.judge_vld); end
            end
            cyc(2'b00, 2'b00);
        end
    endtask

    task automatic test_ok_great();
        clr();
        cyc(2'b01, 2'b00);
        idle(3);
        cyc(2'b00, 2'b01);
        n_cmp++; if (bus.judge_grade !== 4'b0001) begin n_bad++; $display("FAIL t2_ok_grade got %b want 0001", bus.judge_grade); end
        cyc(2'b00, 2'b00);
        n_cmp++; if (bus.score !== 16'h0001) begin n_bad++; $display("FAIL t2_ok_score got %h want 0001", bus.score); end
        cyc(2'b01, 2'b00);
        idle(15);
        cyc(2'b00, 2'b01);
        n_cmp++; if (bus.judge_grade !== 4'b0010) begin n_bad++; $display("FAIL t2_great_grade got %b want 0010", bus.judge_grade); end
        cyc(2'b00, 2'b00);
        n_cmp++; if (bus.score !== 16'h0004) begin n_bad++; $display("FAIL t2_great_score got %h want 0004", bus.score); end
        n_cmp++; if (bus.combo !== 16'h0002) begin n_bad++; $display("FAIL t2_combo got %h want 0002", bus.combo); end
    endtask

    task automatic test_timeout();
        clr();
        cyc(2'b01, 2'b01);
        n_cmp++; if (bus.judge_grade !== 4'b0001) begin n_bad++; $display("FAIL t3_same_cycle_grade got %b want 0001", bus.judge_grade); end
        cyc(2'b00, 2'b00);
        n_cmp++; if (bus.combo !== 16'h0001) begin n_bad++; $display("FAIL t3_pre_combo got %h want 0001", bus.combo); end
        cyc(2'b10, 2'b00);
        idle(20);
        n_cmp++; if (bus.judge_vld !== 1'b0) begin n_bad++; $display("FAIL t3_early_miss got %b want 0", bus.judge_vld); end
        cyc(2'b00, 2'b00);
        n_cmp++; if (bus.judge_vld !== 1'b1) begin n_bad++; $display("FAIL t3_vld got %b want 1", bus.judge_vld); end
        n_cmp++; if (bus.judge_grade !== 4'b0000) begin n_bad++; $display("FAIL t3_grade got %b want 0000", bus.judge_grade); end
        n_cmp++; if (bus.miss_flash !== 2'b10) begin n_bad++; $display("FAIL t3_miss_flash got %b want 10", bus.miss_flash); end
        cyc(2'b00, 2'b00);
        n_cmp++; if (bus.num_misses !== 16'h0001) begin n_bad++; $display("FAIL t3_misses got %h want 0001", bus.num_misses); end
        n_cmp++; if (bus.combo !== 16'h0000) begin n_bad++; $display("FAIL t3_combo got %h want 0000", bus.combo); end
        n_cmp++; if (bus.score !== 16'h0001) begin n_bad++; $display("FAIL t3_score got %h want 0001", bus.score); end
    endtask

    task automatic test_dual();
        clr();
        cyc(2'b11, 2'b00);
        idle(10);
        cyc(2'b00, 2'b11);
        n_cmp++; if (bus.judge_vld !== 1'b1) begin n_bad++; $display("FAIL t4_vld got %b want 1", bus.judge_vld); end
        n_cmp++; if (bus.judge_grade !== 4'b1111) begin n_bad++; $display("FAIL t4_grade got %b want 1111", bus.judge_grade); end
        n_cmp++; if (bus.hit_flash !== 2'b11) begin n_bad++; $display("FAIL t4_hit_flash got %b want 11", bus.hit_flash); end
        cyc(2'b00, 2'b00);
        n_cmp++; if (bus.judge_vld !== 1'b0) begin n_bad++; $display("FAIL t4_vld_pulse got %b want 0", bus.judge_vld); end
        n_cmp++; if (bus.score !== 16'h0010) begin n_bad++; $display("FAIL t4_score got %h want 0010", bus.score); end
        n_cmp++; if (bus.combo !== 16'h0002) begin n_bad++; $display("FAIL t4_combo got %h want 0002", bus.combo); end
    endtask

    task automatic test_stray();
        clr();
        cyc(2'b10, 2'b10);
        cyc(2'b01, 2'b00);
        n_cmp++; if (bus.combo !== 16'h0001) begin n_bad++; $display("FAIL t5_pre_combo got %h want 0001", bus.combo); end
        idle(10);
        cyc(2'b00, 2'b11);
        n_cmp++; if (bus.judge_grade !== 4'b0011) begin n_bad++; $display("FAIL t5_grade got %b want 0011", bus.judge_grade); end
        n_cmp++; if (bus.hit_flash !== 2'b01) begin n_bad++; $display("FAIL t5_hit_flash got %b want 01", bus.hit_flash); end
        n_cmp++; if (bus.miss_flash !== 2'b10) begin n_bad++; $display("FAIL t5_miss_flash got %b want 10", bus.miss_flash); end
        cyc(2'b00, 2'b00);
        n_cmp++; if (bus.score !== 16'h0006) begin n_bad++; $display("FAIL t5_score got %h want 0006", bus.score); end
        n_cmp++; if (bus.num_misses !== 16'h0001) begin n_bad++; $display("FAIL t5_misses got %h want 0001", bus.num_misses); end
        n_cmp++; if (bus.combo !== 16'h0000) begin n_bad++; $display("FAIL t5_combo got %h want 0000", bus.combo); end
    endtask

    task automatic test_saturate_clear();
        clr();
        // open+press in one cycle on both lanes: two OK hits (+2) per clock
        repeat (4999) cyc(2'b11, 2'b11);
        cyc(2'b00, 2'b00);
        n_cmp++; if (bus.score !== 16'h9998) begin n_bad++; $display("FAIL t6_preload got %h want 9998", bus.score); end
        n_cmp++; if (bus.combo !== 16'h9998) begin n_bad++; $display("FAIL t6_combo_pre got %h want 9998", bus.combo); end
        cyc(2'b01, 2'b00);
        idle(10);
        cyc(2'b00, 2'b01);
        cyc(2'b00, 2'b00);
        n_cmp++; if (bus.score !== 16'h9999) begin n_bad++; $display("FAIL t6_sat_score got %h want 9999", bus.score); end
        n_cmp++; if (bus.combo !== 16'h9999) begin n_bad++; $display("FAIL t6_sat_combo got %h want 9999", bus.combo); end
        n_cmp++; if (bus.hit_flash !== 2'b01) begin n_bad++; $display("FAIL t6_flash_pre got %b want 01", bus.hit_flash); end
        bus.score_clr = 1'b1;
        cyc(2'b11, 2'b11);
        bus.score_clr = 1'b0;
        n_cmp++; if ({bus.score, bus.combo, bus.num_misses} !== 48'h0) begin n_bad++; $display("FAIL t6_clr_cnt got %h want 0", {bus.score, bus.combo, bus.num_misses}); end
        n_cmp++; if ({bus.judge_vld, bus.hit_flash, bus.miss_flash} !== 5'b0) begin n_bad++; $display("FAIL t6_clr_flags got %b want 0", {bus.judge_vld, bus.hit_flash, bus.miss_flash}); end
        cyc(2'b00, 2'b00);
        n_cmp++; if ({bus.score, bus.combo, bus.num_misses} !== 48'h0) begin n_bad++; $display("FAIL t6_clr_pending got %h want 0", {bus.score, bus.combo, bus.num_misses}); end
        cyc(2'b00, 2'b01);
        n_cmp++; if ({bus.hit_flash, bus.miss_flash} !== 4'b0001) begin n_bad++; $display("FAIL t6_clr_idle got %b want 0001", {bus.hit_flash, bus.miss_flash}); end
    endtask

    task automatic test_midreset();
        clr();
        cyc(2'b01, 2'b01);
        cyc(2'b00, 2'b00);
        n_cmp++; if (bus.score !== 16'h0001) begin n_bad++; $display("FAIL t7_pre_score got %h want 0001", bus.score); end
        #2 n_rst = 1'b0;
        #1;
        n_cmp++; if ({bus.score, bus.combo} !== 32'h0) begin n_bad++; $display("FAIL t7_async_cnt got %h want 0", {bus.score, bus.combo}); end
        n_cmp++; if (bus.hit_flash !== 2'b00) begin n_bad++; $display("FAIL t7_async_flash got %b want 00", bus.hit_flash); end
        @(negedge clk);
        n_rst = 1'b1;
        cyc(2'b00, 2'b01);
        n_cmp++; if (bus.miss_flash !== 2'b01) begin n_bad++; $display("FAIL t7_stray got %b want 01", bus.miss_flash); end
        cyc(2'b00, 2'b00);
        n_cmp++; if (bus.num_misses !== 16'h0001) begin n_bad++; $display("FAIL t7_misses got %h want 0001", bus.num_misses); end
    endtask

    initial begin
        test_reset();
        test_perfect();
        test_ok_great();
        test_timeout();
        test_dual();
        test_stray();
        test_saturate_clear();
        test_midreset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
